bar_dodge_engine: RTL

//  Parametrised game-state engine for the falling-bar dodge game. Drives NUM_BARS

---
 rtl/bar_dodge_pkg.sv | 21 ++
 rtl/bar_dodge_engine_lfsr8.sv | 26 ++
 rtl/bar_dodge_engine.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/bar_dodge_pkg.sv
// Shared types and constants for the falling-bar dodge game engine.
package bar_dodge_pkg;

    // Game sequencing states; encoding is visible on the state output.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } state_e;

    // Right-shift Galois taps for x^8+x^6+x^5+x^4+1 (maximal length, period 255).
    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam logic [7:0] LFSR_SEED_DEF = 8'hA5;

    // One Galois step; a non-zero state never maps to zero.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {1'b0, v[7:1]} ^ (v[0] ? LFSR_TAPS : 8'h00);
    endfunction

endpackage

// File: rtl/bar_dodge_engine_lfsr8.sv
// Free-running 8-bit Galois LFSR used as the hole-position entropy source.
module lfsr8
    import bar_dodge_pkg::*;
#(
    parameter logic [7:0] SEED = LFSR_SEED_DEF
) (
    input  logic       gameclk,
    input  logic       clr,
    input  logic       en_i,
    output logic [7:0] q_o
);

    // A zero seed would lock the register at zero, so substitute 1.
    localparam logic [7:0] SEED_NZ = (SEED == 8'h00) ? 8'h01 : SEED;

    logic [7:0] lfsr_q;

    // Step the register whenever enabled; clr reloads the seed.
    always_ff @(posedge gameclk or posedge clr) begin
        if (clr)       lfsr_q <= SEED_NZ;
        else if (en_i) lfsr_q <= lfsr_step(lfsr_q);
    end

    assign q_o = lfsr_q;

endmodule

// File: rtl/bar_dodge_engine.sv
// Game-state engine: moves NUM_BARS staggered bars down the field, judges the
// player against each bar's gap at the bottom row, and sequences
// idle/play/hit/game-over while keeping lives, time alive and bars cleared.
module bar_dodge_engine
    import bar_dodge_pkg::*;
#(
    parameter int         FIELD_W    = 16,
    parameter int         FIELD_H    = 12,
    parameter int         HOLE_W     = 3,
    parameter int         NUM_BARS   = 2,
    parameter int         LIVES_INIT = 3,
    parameter int         HIT_TICKS  = 4,
    parameter int         SCORE_W    = 16,
    parameter logic [7:0] LFSR_SEED  = LFSR_SEED_DEF,
    localparam int        COL_W      = $clog2(FIELD_W),
    localparam int        ROW_W      = $clog2(FIELD_H)
) (
    input  logic                        gameclk,
    input  logic                        clr,
    input  logic                        tick,
    input  logic                        start,
    input  logic [COL_W-1:0]            plrpos,
    output logic [NUM_BARS*ROW_W-1:0]   barpos,
    output logic [NUM_BARS*COL_W-1:0]   holepos,
    output logic [2:0]                  lives,
    output logic [SCORE_W-1:0]          timealive,
    output logic [SCORE_W-1:0]          cleared,
    output logic [1:0]                  state,
    output logic                        hit
);

    localparam int              BAR_GAP   = FIELD_H / NUM_BARS;
    localparam int              HOLE_SPAN = FIELD_W - HOLE_W + 1;
    localparam int              HC_W      = (HIT_TICKS > 1) ? $clog2(HIT_TICKS) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FIELD_H - 1);
    // Gap right edge offset, widened by one bit so hole+offset cannot wrap.
    localparam logic [COL_W:0]  HOLE_EXT  = (COL_W+1)'(HOLE_W - 1);

    state_e               state_q, state_d;
    logic [2:0]           lives_q, lives_d;
    logic [SCORE_W-1:0]   time_q, time_d;
    logic [SCORE_W-1:0]   clrd_q, clrd_d;
    logic [HC_W-1:0]      hcnt_q, hcnt_d;
    logic                 hit_q, hit_d;
    logic [ROW_W-1:0]     row_q  [NUM_BARS];
    logic [ROW_W-1:0]     row_d  [NUM_BARS];
    logic [COL_W-1:0]     hole_q [NUM_BARS];
    logic [COL_W-1:0]     hole_d [NUM_BARS];
    logic [7:0]           lfsr_q;

    // Working variables of the judge block.
    logic [7:0]           rnd;
    logic                 miss_any;
    logic [COL_W:0]       plr_x;
    logic [COL_W:0]       lo_x;

    // The LFSR free-runs every cycle so hole choice depends on player timing.
    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .gameclk (gameclk),
        .clr     (clr),
        .en_i    (1'b1),
        .q_o     (lfsr_q)
    );

    // Judge/priority logic: bar motion, pass/miss, scoring and next state.
    always_comb begin
        state_d  = state_q;
        lives_d  = lives_q;
        time_d   = time_q;
        clrd_d   = clrd_q;
        hcnt_d   = hcnt_q;
        hit_d    = 1'b0;
        row_d    = row_q;
        hole_d   = hole_q;
        rnd      = lfsr_q;
        miss_any = 1'b0;
        plr_x    = {1'b0, plrpos};
        lo_x     = '0;
        if (tick) begin
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    // Restart reloads the same values as reset.
                    if (start) begin
                        state_d = ST_PLAY;
                        lives_d = 3'(LIVES_INIT);
                        time_d  = '0;
                        clrd_d  = '0;
                        hcnt_d  = '0;
                        for (int i = 0; i < NUM_BARS; i++) begin
                            row_d[i]  = ROW_W'(i * BAR_GAP);
                            hole_d[i] = '0;
                        end
                    end
                end
                ST_PLAY: begin
                    if (time_q != '1) time_d = time_q + 1'b1;
                    for (int i = 0; i < NUM_BARS; i++) begin
                        if (row_q[i] == ROW_LAST) begin
                            lo_x = {1'b0, hole_q[i]};
                            if (plr_x >= lo_x && plr_x <= lo_x + HOLE_EXT) begin
                                if (clrd_d != '1) clrd_d = clrd_d + 1'b1;
                            end else begin
                                miss_any = 1'b1;
                            end
                            // Respawning bars draw successive LFSR values by index.
                            row_d[i]  = '0;
                            hole_d[i] = COL_W'(32'(rnd) % HOLE_SPAN);
                            rnd       = lfsr_step(rnd);
                        end else begin
                            row_d[i] = row_q[i] + 1'b1;
                        end
                    end
                    // Several misses on one tick still cost a single life.
                    if (miss_any) begin
                        hit_d   = 1'b1;
                        lives_d = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
                        if (lives_q <= 3'd1) begin
                            state_d = ST_OVER;
                        end else begin
                            state_d = ST_HIT;
                            hcnt_d  = HC_W'(HIT_TICKS - 1);
                        end
                    end
                end
                ST_HIT: begin
                    if (hcnt_q == '0) state_d = ST_PLAY;
                    else              hcnt_d  = hcnt_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sequencing, lives and score registers; hit is a one-cycle pulse.
    always_ff @(posedge gameclk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            lives_q <= 3'(LIVES_INIT);
            time_q  <= '0;
            clrd_q  <= '0;
            hcnt_q  <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            time_q  <= time_d;
            clrd_q  <= clrd_d;
            hcnt_q  <= hcnt_d;
            hit_q   <= hit_d;
        end
    end

    for (genvar g = 0; g < NUM_BARS; g++) begin : g_bar
        localparam logic [ROW_W-1:0] ROW_INIT = ROW_W'(g * BAR_GAP);

        // Per-bar row and gap registers, staggered at reset.
        always_ff @(posedge gameclk or posedge clr) begin
            if (clr) begin
                row_q[g]  <= ROW_INIT;
                hole_q[g] <= '0;
            end else begin
                row_q[g]  <= row_d[g];
                hole_q[g] <= hole_d[g];
            end
        end
    end

    // Pack per-bar registers onto the flat renderer buses.
    always_comb begin
        barpos  = '0;
        holepos = '0;
        for (int i = 0; i < NUM_BARS; i++) begin
            barpos[i*ROW_W +: ROW_W]  = row_q[i];
            holepos[i*COL_W +: COL_W] = hole_q[i];
        end
    end

    assign lives     = lives_q;
    assign timealive = time_q;
    assign cleared   = clrd_q;
    assign state     = state_q;
    assign hit       = hit_q;

endmodule
